iss_discrete_driver: RTL and testbench
======================================

# iss_discrete_driver

AGC-side driver for the ISS discrete interface of the CDU digital-mode logic. Generates the 51.2 kpps reference clock `_51KPHI` and drives the `ISSCA`, `ISSZ` and `ISSEEC` command discretes in response to a valid/ready command port. It checks the CDU's echoes on `DMMCA` and `ISSZDR`, then reports done or error. It sits between the AGC channel-output model and the CDU digital-mode block, in the simulation top level and in bench harnesses.

## Interface
- `DIV`, default 4: clk cycles per half-period of `_51KPHI`. Must be ≥2.
- `ZERO_MIN`, default 16: number of ticks that `ISSZ` is held high during a zero operation. Must be ≥1.
- `ACK_TIMEOUT`, default 8: number of ticks to wait for `DMMCA` after coarse align is enabled. Must be ≥1.
- `clk` in 1: system clock. There is only one clock.
- `rst` in 1: reset. Synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 1: 0 = SET discretes, 1 = ZERO pulse.
- `cmd_data` in 2: bit0 = CA level, bit1 = EEC level. Used only by SET.
- `ISSZDR` in 1: zero echo from the CDU.
- `DMMCA` in 1: coarse-align echo from the CDU.
- `_51KPHI` out 1: reference clock to the CDU.
- `ISSCA`, `ISSZ`, `ISSEEC` out 1 each: ISS discretes.
- `busy` out 1: equal to the inverse of `cmd_ready`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag.

## Operation
- **Divider**
  - Counter runs from 0 to DIV-1. `_51KPHI` toggles when the counter wraps.
  - `tick` is an internal one-cycle strobe, asserted in the clk cycle in which `_51KPHI` goes 0→1.
  - Every discrete output changes only in a tick cycle.
- **Latched levels**
  - `ca_q` and `eec_q` hold the last SET values.
  - Drive rules: `ISSCA` = `ca_q`. `ISSEEC` = `eec_q` AND NOT `ISSZ`; EEC is interlocked off while zeroing.
- **FSM states**
  - IDLE
    - `cmd_ready`=1.
    - On accept (`cmd_valid` & `cmd_ready`): latch `cmd_op` and `cmd_data`, clear `err`.
    - Go to SET_APPLY if `cmd_op`=0, otherwise to Z_ASSERT.
  - SET_APPLY: on tick, load `ca_q` and `eec_q`.
    - New CA=1 with previous CA=0: go to CA_WAIT with the timer cleared.
    - Any other case: pulse `done` and go to IDLE.
  - CA_WAIT: samples `DMMCA` every clk.
    - `DMMCA`=1: pulse `done`, go to IDLE.
    - Timer counts ticks. When it reaches ACK_TIMEOUT without `DMMCA`: set `err`, pulse `done`, go to IDLE.
  - Z_ASSERT: on tick, set `ISSZ`=1, clear the hold counter and `echo_seen`, go to Z_HOLD.
  - Z_HOLD
    - Any clk cycle with `ISSZDR`=1 sets `echo_seen`.
    - Count ticks. On the ZERO_MIN-th tick, `ISSZ`→0 in that same tick cycle.
    - If `echo_seen` is clear at that point, including an echo arriving in that same cycle, set `err`. Then pulse `done` and go to IDLE.
- **Restrictions**
  - CA and EEC levels are unchanged by ZERO.
  - Commands are not queued.
  - `cmd_data` is ignored for ZERO.

## Timing
- **Reset values:** `_51KPHI`=0, divider=0, `ISSCA`=`ISSZ`=`ISSEEC`=0, `ca_q`=`eec_q`=0, `done`=0, `err`=0, FSM=IDLE.
  - `cmd_ready`=0 while `rst` is high and 1 in the first cycle after `rst` falls.
- **Reset mid-operation** (including Z_HOLD): all outputs return to the reset values on the next clk edge; `ISSZ` drops immediately, without waiting for a tick.
- **First tick after reset:** 2·DIV cycles after reset release.
- **Period:** `_51KPHI` period is 2·DIV clk cycles. Tick spacing is 2·DIV cycles.
- **SET latency:** discretes update at the first tick strictly after the accept cycle, i.e. 1 to 2·DIV cycles later.
  - A command accepted in a tick cycle waits for the next tick.
- **ZERO timing:** `ISSZ` is high for exactly ZERO_MIN ticks (ZERO_MIN·2·DIV cycles). `ISSEEC` is low for exactly that window.
- **`done`:**
  - Asserts in the same cycle as the final output change. In the CA_WAIT success case, it asserts in the cycle `DMMCA` is sampled.
  - `cmd_ready` returns in the following cycle.
- **Simultaneous events:** `DMMCA`=1 in the same cycle as the timeout tick counts as success.
- **Echo sampling:** `ISSZDR` and `DMMCA` are sampled with no synchronizer; they are assumed synchronous to `clk`.

## Test plan
- **Reset:** DIV=4; release `rst`.
  - All discretes are 0 and `cmd_ready`=1 one cycle after release.
  - First `_51KPHI` rise is 8 cycles after release; period is 8.
- **SET EEC only:** SET `cmd_data`=2'b10.
  - `ISSEEC`=1 at the next tick; `ISSCA`=0.
  - `done` pulses once, `err`=0.
- **SET CA with echo:** SET CA=1; bench drives `DMMCA`=1 three ticks later.
  - `ISSCA`=1 at the first tick; `done` pulses in the cycle `DMMCA` is sampled high; `err`=0.
  - Repeat with `DMMCA` held at 0: `done` and `err`=1 on the 8th tick.
- **ZERO with EEC on:** `eec_q`=1, ZERO_MIN=16; issue ZERO; pulse `ISSZDR` during the hold.
  - `ISSZ` is high for exactly 128 cycles; `ISSEEC`=0 throughout that window and 1 again at its end.
  - `err`=0.
- **ZERO without echo:** `ISSZDR` held at 0.
  - `err`=1 at `ISSZ` release.
  - The next accepted command clears `err`.
- **Reset mid-zero:** assert `rst` in Z_HOLD.
  - `ISSZ`=0 on the next edge; `cmd_ready` is back at 1 one cycle after `rst` falls; no `done` pulse.

Source files
------------

// File: rtl/iss_discrete_driver_if.sv
// iss_discrete_driver_if: command port between the AGC channel-output model and the ISS discrete driver
// Signals:
//   cmd_valid, cmd_op, cmd_data   request from the AGC side (op 0 = SET, 1 = ZERO; data[0] = CA, data[1] = EEC)
//   cmd_ready, busy               driver accepts only while idle; busy is its inverse
//   done, err                     one-cycle completion pulse and sticky error flag
interface iss_discrete_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [1:0] cmd_data;
    logic       busy;
    logic       done;
    logic       err;
    modport master(output cmd_valid, cmd_op, cmd_data, input cmd_ready, busy, done, err);
    modport slave(input cmd_valid, cmd_op, cmd_data, output cmd_ready, busy, done, err);
endinterface

// File: rtl/iss_discrete_driver.sv
// iss_discrete_driver: AGC-side ISS discrete driver with 51.2 kpps reference clock and CDU echo checks
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   cmd                  command port (slave side of iss_discrete_driver_if)
//   ISSZDR, DMMCA        zero and coarse-align echoes from the CDU, assumed synchronous to clk
//   _51KPHI              reference clock to the CDU, period 2*DIV clk cycles
//   ISSCA, ISSZ, ISSEEC  ISS command discretes, changing only on tick cycles (or reset)
module iss_discrete_driver #(
    parameter int DIV         = 4,
    parameter int ZERO_MIN    = 16,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    iss_discrete_driver_if.slave cmd,
    input  logic                 ISSZDR,
    input  logic                 DMMCA,
    output logic                 _51KPHI,
    output logic                 ISSCA,
    output logic                 ISSZ,
    output logic                 ISSEEC
);
    localparam int CW = $clog2(DIV);
    localparam int HW = $clog2(ZERO_MIN + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SET_APPLY, CA_WAIT, Z_ASSERT, Z_HOLD, DONE} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    data_q, data_d;
    logic          phi_q, phi_d, arm_q, arm_d;
    logic          ca_q, ca_d, eec_q, eec_d, issz_q, issz_d;
    logic          err_q, err_d, echo_q, echo_d;
    logic          wrap, tick, ready;
    assign wrap  = div_q == CW'(DIV - 1);
    // arm_q swallows the first wrap so the first rising edge lands a full period after reset
    assign tick  = wrap & arm_q & ~phi_q;
    assign ready = (state_q == IDLE) & ~rst;
    always_comb begin
        div_d   = wrap ? '0 : div_q + CW'(1);
        arm_d   = arm_q | wrap;
        phi_d   = (wrap & arm_q) ? ~phi_q : phi_q;
        state_d = state_q;
        data_d  = data_q;
        ca_d    = ca_q;
        eec_d   = eec_q;
        issz_d  = issz_q;
        err_d   = err_q;
        echo_d  = echo_q;
        hold_d  = hold_q;
        tmr_d   = tmr_q;
        unique case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    data_d  = cmd.cmd_data;
                    err_d   = 1'b0;
                    state_d = cmd.cmd_op ? Z_ASSERT : SET_APPLY;
                end
            end
            SET_APPLY: begin
                if (tick) begin
                    ca_d    = data_q[0];
                    eec_d   = data_q[1];
                    tmr_d   = '0;
                    state_d = (data_q[0] & ~ca_q) ? CA_WAIT : DONE;
                end
            end
            CA_WAIT: begin
                // an echo in the timeout tick cycle still wins over the timeout
                if (DMMCA) state_d = DONE;
                else if (tick) begin
                    if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else tmr_d = tmr_q + TW'(1);
                end
            end
            Z_ASSERT: begin
                if (tick) begin
                    issz_d  = 1'b1;
                    hold_d  = '0;
                    echo_d  = 1'b0;
                    state_d = Z_HOLD;
                end
            end
            Z_HOLD: begin
                echo_d = echo_q | ISSZDR;
                if (tick) begin
                    if (hold_q == HW'(ZERO_MIN - 1)) begin
                        issz_d  = 1'b0;
                        err_d   = ~(echo_q | ISSZDR);
                        state_d = DONE;
                    end else hold_d = hold_q + HW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            phi_q   <= 1'b0;
            arm_q   <= 1'b0;
            data_q  <= '0;
            ca_q    <= 1'b0;
            eec_q   <= 1'b0;
            issz_q  <= 1'b0;
            err_q   <= 1'b0;
            echo_q  <= 1'b0;
            hold_q  <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            phi_q   <= phi_d;
            arm_q   <= arm_d;
            data_q  <= data_d;
            ca_q    <= ca_d;
            eec_q   <= eec_d;
            issz_q  <= issz_d;
            err_q   <= err_d;
            echo_q  <= echo_d;
            hold_q  <= hold_d;
            tmr_q   <= tmr_d;
        end
    end
    assign cmd.cmd_ready = ready;
    assign cmd.busy      = ~ready;
    assign cmd.done      = state_q == DONE;
    assign cmd.err       = err_q;
    assign _51KPHI       = phi_q;
    assign ISSCA         = ca_q;
    assign ISSZ          = issz_q;
    // EEC is interlocked off for the whole zero window
    assign ISSEEC        = eec_q & ~issz_q;
endmodule

// File: tb/tb_iss_discrete_driver.sv
// tb_iss_discrete_driver: self-checking bench for iss_discrete_driver
module tb_iss_discrete_driver;
    localparam int DIV = 4, ZERO_MIN = 16, ACK_TIMEOUT = 8;
    localparam int P = 2 * DIV, ZW = ZERO_MIN * P, AW = ACK_TIMEOUT * P;
    typedef struct {
        bit       op;
        bit [1:0] data;
        int       eo;
        int       exp_doff;
        bit       exp_ca;
        bit       exp_eec;
        bit       exp_err;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, ISSZDR = 1'b0, DMMCA = 1'b0;
    logic phi, ISSCA, ISSZ, ISSEEC;
    int cyc, checks, passed;
    bit m_ca, m_eec;
    vec_t vecs[11];
    iss_discrete_driver_if bus();
    iss_discrete_driver #(.DIV(DIV), .ZERO_MIN(ZERO_MIN), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd(bus.slave), .ISSZDR(ISSZDR), .DMMCA(DMMCA),
        ._51KPHI(phi), .ISSCA(ISSCA), .ISSZ(ISSZ), .ISSEEC(ISSEEC)
    );
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endfunction
    task automatic step;
        @(negedge clk);
        cyc++;
    endtask
    function automatic bit phi_exp(int c);
        return c >= P && (c % P) < DIV;
    endfunction
    task automatic run_cmd(input bit op, input bit [1:0] data, input int eo, output int doff);
        int a, t1, dv;
        bit rise, ok_echo, nerr, z, ca_l, eec_l;
        logic [7:0] act, exp;
        a       = cyc;
        t1      = a + 1 + (P - 1 - (a + 1) % P);
        rise    = !op && data[0] && !m_ca;
        ok_echo = eo >= 1 && eo <= (op ? ZW : AW);
        dv      = op ? t1 + ZW + 1 : rise ? (ok_echo ? t1 + eo + 1 : t1 + AW + 1) : t1 + 1;
        nerr    = (op || rise) && !ok_echo;
        chk("accept_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        doff = -1;
        for (int c = a + 1; c <= dv + 1; c++) begin
            step;
            bus.cmd_valid = 1'b0;
            bus.cmd_op    = 1'($urandom);
            bus.cmd_data  = 2'($urandom);
            ca_l  = (c > t1 && !op) ? data[0] : m_ca;
            eec_l = (c > t1 && !op) ? data[1] : m_eec;
            z     = op && c > t1 && c <= t1 + ZW;
            act = {phi, ISSCA, ISSZ, ISSEEC, bus.done, bus.cmd_ready, bus.busy, bus.err};
            exp = {phi_exp(c), ca_l, z, eec_l & ~z, c == dv, c > dv, c <= dv, c >= dv && nerr};
            chk("cycle{phi,ca,z,eec,done,ready,busy,err}", 32'(act), 32'(exp));
            if (bus.done && doff < 0) doff = c - t1;
            DMMCA  = !op && eo >= 0 && c == t1 + eo;
            ISSZDR = op && eo >= 0 && c == t1 + eo;
        end
        DMMCA  = 1'b0;
        ISSZDR = 1'b0;
        if (!op) begin
            m_ca  = data[0];
            m_eec = data[1];
        end
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        int doff;
        bit op;
        bit [1:0] data;
        int eo;
        vecs[0]  = '{0, 2'b10, -1,   1, 0, 1, 0};
        vecs[1]  = '{0, 2'b11, 24,  25, 1, 1, 0};
        vecs[2]  = '{0, 2'b01, -1,   1, 1, 0, 0};
        vecs[3]  = '{0, 2'b00, -1,   1, 0, 0, 0};
        vecs[4]  = '{0, 2'b01, -1,  65, 1, 0, 1};
        vecs[5]  = '{0, 2'b10, -1,   1, 0, 1, 0};
        vecs[6]  = '{1, 2'b11, 50, 129, 0, 1, 0};
        vecs[7]  = '{1, 2'b00, -1, 129, 0, 1, 1};
        vecs[8]  = '{0, 2'b11, 64,  65, 1, 1, 0};
        vecs[9]  = '{1, 2'b00, 128, 129, 1, 1, 0};
        vecs[10] = '{1, 2'b10, 0,  129, 1, 1, 1};
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_data  = 2'b00;
        // reset state and divider phase
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.cmd_ready), 0);
        chk("rst_busy", 32'(bus.busy), 1);
        chk("rst_outs", 32'({phi, ISSCA, ISSZ, ISSEEC, bus.done, bus.err}), 0);
        rst = 1'b0;
        cyc = 0;
        m_ca = 1'b0;
        m_eec = 1'b0;
        #1;
        chk("release_ready", 32'(bus.cmd_ready), 1);
        chk("release_phi", 32'(phi), 0);
        for (int c = 1; c <= 16; c++) begin
            step;
            chk("phi_phase", 32'(phi), 32'((c >= 8 && c < 12) || c == 16));
        end
        // directed table
        foreach (vecs[i]) begin
            run_cmd(vecs[i].op, vecs[i].data, vecs[i].eo, doff);
            chk("vec_done_offset", 32'(doff), 32'(vecs[i].exp_doff));
            chk("vec_issca", 32'(ISSCA), 32'(vecs[i].exp_ca));
            chk("vec_isseec", 32'(ISSEEC), 32'(vecs[i].exp_eec));
            chk("vec_err", 32'(bus.err), 32'(vecs[i].exp_err));
        end
        // reset in the middle of a zero hold
        chk("midzero_ready", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 1'b1;
        step;
        bus.cmd_valid = 1'b0;
        repeat (40) step;
        chk("midzero_issz_high", 32'(ISSZ), 1);
        rst = 1'b1;
        step;
        chk("midzero_issz_drop", 32'(ISSZ), 0);
        chk("midzero_outs", 32'({ISSCA, ISSEEC, bus.done, bus.err, bus.cmd_ready}), 0);
        step;
        chk("midzero_no_done", 32'(bus.done), 0);
        rst = 1'b0;
        cyc = 0;
        m_ca = 1'b0;
        m_eec = 1'b0;
        #1;
        chk("midzero_ready_back", 32'(bus.cmd_ready), 1);
        chk("midzero_no_done2", 32'(bus.done), 0);
        // randomized commands against the transaction-level model
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 9)) step;
            op   = ($urandom % 3) == 0;
            data = 2'($urandom);
            eo   = ($urandom % 4 == 0) ? -1 : int'($urandom_range(0, op ? ZW + 10 : AW + 10));
            run_cmd(op, data, eo, doff);
            chk("rand_done_seen", 32'(doff >= 0), 1);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
